// File: rtl/spi_master_if.sv
// Signal bundle between the SPI master and its user/serial side.
// dbg_state exposes the master's FSM state for checkers.
interface spi_master_if;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       ss_n;
    logic [1:0] dbg_state;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, mosi, ss_n, dbg_state
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, mosi, ss_n, dbg_state
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master: one byte per transfer, MSB first, SCLK half-period = CLK_DIV clocks.
// Define SPI_MASTER_BURST_EN to chain transfers without releasing ss_n (start in last HOLD cycle).
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master bus
);
    // Handshake: start is sampled only while busy=0 (IDLE); the accepting edge raises busy.
    // done pulses for one cycle when rx_data takes the new byte; start in that cycle is accepted.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    state_t     r_state, w_state;
    logic [7:0] r_cnt, w_cnt;
    logic [3:0] r_half, w_half;
    logic       r_sclk, w_sclk;
    logic       r_ss_n, w_ss_n;
    logic       r_busy, w_busy;
    logic       r_done, w_done;
    logic [7:0] r_tx, w_tx;
    logic [7:0] r_rx, w_rx;
    logic [7:0] r_rx_data, w_rx_data;
    logic       w_phase_end;

    assign w_phase_end = (r_cnt == DIV_M1);

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_half    = r_half;
        w_sclk    = r_sclk;
        w_ss_n    = r_ss_n;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_tx      = r_tx;
        w_rx      = r_rx;
        w_rx_data = r_rx_data;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_tx    = bus.tx_data;
                    w_ss_n  = 1'b0;
                    w_busy  = 1'b1;
                    w_cnt   = 8'd0;
                    w_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_phase_end) begin
                    w_cnt   = 8'd0;
                    w_half  = 4'd0;
                    w_sclk  = 1'b1;
                    w_rx    = {r_rx[6:0], bus.miso};
                    w_state = ST_XFER;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            ST_XFER: begin
                if (w_phase_end) begin
                    w_cnt = 8'd0;
                    if (r_half == 4'd15) begin
                        w_state = ST_HOLD;
                    end else begin
                        w_half = r_half + 4'd1;
                        w_sclk = ~r_sclk;
                        // Even half-periods are high, so r_sclk=0 here means a rising edge.
                        if (!r_sclk) begin
                            w_rx = {r_rx[6:0], bus.miso};
                        end else if (r_half < 4'd14) begin
                            w_tx = {r_tx[6:0], 1'b0};
                        end
                    end
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (w_phase_end) begin
                    w_cnt     = 8'd0;
                    w_done    = 1'b1;
                    w_rx_data = r_rx;
`ifdef SPI_MASTER_BURST_EN
                    if (bus.start) begin
                        w_tx    = bus.tx_data;
                        w_half  = 4'd0;
                        w_sclk  = 1'b1;
                        w_rx    = {r_rx[6:0], bus.miso};
                        w_state = ST_XFER;
                    end else begin
                        w_ss_n  = 1'b1;
                        w_busy  = 1'b0;
                        w_tx    = 8'd0;
                        w_state = ST_IDLE;
                    end
`else
                    w_ss_n  = 1'b1;
                    w_busy  = 1'b0;
                    w_tx    = 8'd0;
                    w_state = ST_IDLE;
`endif
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_half    <= 4'd0;
            r_sclk    <= 1'b0;
            r_ss_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tx      <= 8'd0;
            r_rx      <= 8'd0;
            r_rx_data <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_half    <= w_half;
            r_sclk    <= w_sclk;
            r_ss_n    <= w_ss_n;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_tx      <= w_tx;
            r_rx      <= w_rx;
            r_rx_data <= w_rx_data;
        end
    end

    // mosi is the top of the tx shift register, which is cleared when the frame ends.
    assign bus.mosi      = r_tx[7];
    assign bus.sclk      = r_sclk;
    assign bus.ss_n      = r_ss_n;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rx_data   = r_rx_data;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: mode-0 slave model, bus monitor, per-scenario test tasks.
// Main DUT uses CLK_DIV=2, a second instance uses CLK_DIV=1.
module tb_spi_master;
    localparam int DIV = 2;
`ifdef SPI_MASTER_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic clk;
    logic rst;
    spi_master_if bus();
    spi_master_if bus1();

    spi_master #(.CLK_DIV(DIV)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    spi_master #(.CLK_DIV(1))   u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1);
    end

    // Mode-0 slave: presents bit 7 when selected, next bit after each sclk fall.
    logic [7:0] slv_byte   = 8'h00;
    int         slv_idx    = 0;
    logic       slv_ss_q   = 1'b1;
    logic       slv_sclk_q = 1'b0;

    always @(bus.ss_n or bus.sclk) begin
        if (bus.ss_n !== slv_ss_q) begin
            slv_ss_q = bus.ss_n;
            if (bus.ss_n === 1'b0) slv_idx = 0;
        end else if (bus.sclk === 1'b0 && slv_sclk_q === 1'b1) begin
            slv_idx = (slv_idx + 1) % 8;
        end
        slv_sclk_q = bus.sclk;
        bus.miso   = slv_byte[7 - slv_idx];
    end

    // Monitor on the main DUT, sampled on the falling clk edge.
    int   mon_rises    = 0;
    int   mon_done     = 0;
    int   mon_done_cyc = 0;
    int   mon_run      = 0;
    int   mon_last_run = 0;
    int   mon_gap      = 0;
    int   mon_last_gap = 0;
    logic mon_sclk_q   = 1'b0;
    logic mon_done_q   = 1'b0;
    logic mon_mosi_q[$];

    always @(negedge clk) begin
        if (bus.sclk === 1'b1 && mon_sclk_q === 1'b0) begin
            mon_rises++;
            mon_mosi_q.push_back(bus.mosi);
        end
        mon_sclk_q = bus.sclk;
        if (bus.done === 1'b1) begin
            mon_done_cyc++;
            if (mon_done_q !== 1'b1) mon_done++;
        end
        mon_done_q = bus.done;
        if (bus.ss_n === 1'b0) begin
            if (mon_gap > 0) mon_last_gap = mon_gap;
            mon_gap = 0;
            mon_run++;
        end else begin
            if (mon_run > 0) mon_last_run = mon_run;
            mon_run = 0;
            mon_gap++;
        end
    end

    // driver tasks
    task automatic drive_start(input logic [7:0] tx);
        @(posedge clk); #1;
        bus.tx_data = tx;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.tx_data = 8'($urandom);
    endtask

    task automatic wait_done(output int cyc, output bit to);
        cyc = 0;
        to  = 1'b0;
        while (!to && bus.done !== 1'b1) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc > 2000) to = 1'b1;
        end
    endtask

    task automatic settle();
        @(negedge clk); #1;
        @(negedge clk); #1;
    endtask

    function automatic logic [7:0] mosi_byte(input int n0);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 0; i < 8; i++)
            if (n0 + i < mon_mosi_q.size()) got[7 - i] = mon_mosi_q[n0 + i];
        return got;
    endfunction

    // test tasks
    task automatic test_reset();
        logic [12:0] obs;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.tx_data  = 8'h00;
        bus1.start   = 1'b0;
        bus1.tx_data = 8'h00;
        bus1.miso    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = {bus.ss_n, bus.sclk, bus.mosi, bus.busy, bus.done, bus.rx_data};
        total++;
        if (obs !== 13'b1_0_0_0_0_00000000) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, 13'b1_0_0_0_0_00000000);
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        obs = {bus1.ss_n, bus1.sclk, bus1.mosi, bus1.busy, bus1.done, bus1.rx_data};
        total++;
        if (obs !== 13'b1_0_0_0_0_00000000 || bus.busy !== 1'b0 || bus.ss_n !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_idle got=%b exp=%b", obs, 13'b1_0_0_0_0_00000000);
        end
    endtask

    task automatic test_basic();
        int n0, d0, dc0, cyc;
        bit to;
        logic [7:0] exp;
        slv_byte = 8'h3C;
        exp_q.push_back(8'h3C);
        n0  = mon_mosi_q.size();
        d0  = mon_done;
        dc0 = mon_done_cyc;
        drive_start(8'hA5);
        wait_done(cyc, to);
        settle();
        total++;
        if (to || cyc != 18 * DIV) begin
            bad++;
            $display("FAIL basic_latency got=%0d exp=%0d", cyc, 18 * DIV);
        end
        exp = exp_q.pop_front();
        total++;
        if (bus.rx_data !== exp) begin
            bad++;
            $display("FAIL basic_rx got=%h exp=%h", bus.rx_data, exp);
        end
        total++;
        if (mon_mosi_q.size() - n0 != 8 || mosi_byte(n0) !== 8'hA5) begin
            bad++;
            $display("FAIL basic_mosi got=%h exp=%h", mosi_byte(n0), 8'hA5);
        end
        total++;
        if (mon_last_run != 36) begin
            bad++;
            $display("FAIL basic_ss_low got=%0d exp=%0d", mon_last_run, 36);
        end
        total++;
        if (mon_done - d0 != 1 || mon_done_cyc - dc0 != 1) begin
            bad++;
            $display("FAIL basic_done_pulse got=%0d/%0d exp=1/1", mon_done - d0, mon_done_cyc - dc0);
        end
    endtask

    task automatic test_random();
        int n0, cyc;
        bit to;
        logic [7:0] tx, exp;
        for (int k = 0; k < 8; k++) begin
            tx       = 8'($urandom);
            slv_byte = 8'($urandom);
            exp_q.push_back(slv_byte);
            n0 = mon_mosi_q.size();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            drive_start(tx);
            wait_done(cyc, to);
            settle();
            exp = exp_q.pop_front();
            total++;
            if (to || bus.rx_data !== exp) begin
                bad++;
                $display("FAIL rand_rx[%0d] got=%h exp=%h", k, bus.rx_data, exp);
            end
            total++;
            if (mosi_byte(n0) !== tx || mon_last_run != 18 * DIV) begin
                bad++;
                $display("FAIL rand_frame[%0d] mosi got=%h exp=%h ss_low got=%0d exp=%0d",
                         k, mosi_byte(n0), tx, mon_last_run, 18 * DIV);
            end
        end
        // rx_data holds between transfers
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (bus.rx_data !== slv_byte) begin
            bad++;
            $display("FAIL rx_hold got=%h exp=%h", bus.rx_data, slv_byte);
        end
    endtask

    task automatic test_div1();
        int lat, alt_err, rises;
        bit to;
        logic prev;
        bus1.miso    = 1'b0;
        bus1.tx_data = 8'hFF;
        @(posedge clk); #1;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start   = 1'b0;
        bus1.tx_data = 8'h00;
        lat     = 0;
        alt_err = 0;
        rises   = 0;
        to      = 1'b0;
        prev    = bus1.sclk;
        while (!to && bus1.done !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
            if (lat <= 16 && bus1.sclk !== ((lat % 2) == 1)) alt_err++;
            if (bus1.sclk === 1'b1 && prev === 1'b0) rises++;
            prev = bus1.sclk;
            if (lat > 100) to = 1'b1;
        end
        total++;
        if (to || lat != 18) begin
            bad++;
            $display("FAIL div1_done_latency got=%0d exp=%0d", lat, 18);
        end
        total++;
        if (alt_err != 0 || rises != 8) begin
            bad++;
            $display("FAIL div1_sclk got=%0d rises %0d bad cycles exp=8 rises 0 bad cycles", rises, alt_err);
        end
        total++;
        if (bus1.rx_data !== 8'h00 || bus1.ss_n !== 1'b1) begin
            bad++;
            $display("FAIL div1_rx got=%h exp=%h", bus1.rx_data, 8'h00);
        end
    endtask

    task automatic test_start_held();
        int n0, d0, r0, cyc, cyc2;
        bit to, to2;
        slv_byte = 8'h5A;
        n0 = mon_mosi_q.size();
        d0 = mon_done;
        r0 = mon_rises;
        @(posedge clk); #1;
        bus.tx_data = 8'h12;
        bus.start   = 1'b1;
        wait_done(cyc, to);
        total++;
        if (to || cyc != 18 * DIV + 1 || bus.rx_data !== 8'h5A) begin
            bad++;
            $display("FAIL held_first got=%0d/%h exp=%0d/%h", cyc, bus.rx_data, 18 * DIV + 1, 8'h5A);
        end
        @(posedge clk); #1;
        total++;
        if (bus.busy !== 1'b1 || bus.ss_n !== 1'b0) begin
            bad++;
            $display("FAIL held_second_accept got=busy %b ss_n %b exp=busy 1 ss_n 0", bus.busy, bus.ss_n);
        end
        bus.start = 1'b0;
        wait_done(cyc2, to2);
        settle();
        total++;
        if (to2 || cyc2 != (BURST ? 17 * DIV - 1 : 18 * DIV)) begin
            bad++;
            $display("FAIL held_second_latency got=%0d exp=%0d", cyc2, BURST ? 17 * DIV - 1 : 18 * DIV);
        end
        total++;
        if (mon_done - d0 != 2 || mon_rises - r0 != 16 ||
            mosi_byte(n0) !== 8'h12 || mosi_byte(n0 + 8) !== 8'h12 || bus.rx_data !== 8'h5A) begin
            bad++;
            $display("FAIL held_two_frames got=%0d dones %0d rises exp=2 dones 16 rises",
                     mon_done - d0, mon_rises - r0);
        end
        total++;
        if (BURST ? (mon_last_run != 35 * DIV) : (mon_last_gap != 1 || mon_last_run != 18 * DIV)) begin
            bad++;
            $display("FAIL held_ss_gap got=gap %0d run %0d exp=gap %0d run %0d",
                     mon_last_gap, mon_last_run, BURST ? 0 : 1, BURST ? 35 * DIV : 18 * DIV);
        end
    endtask

    task automatic test_reset_mid();
        int r, cyc, d0, n0;
        bit to;
        logic prev;
        logic [12:0] obs;
        slv_byte = 8'hC3;
        drive_start(8'h81);
        r    = 0;
        cyc  = 0;
        prev = bus.sclk;
        while (r < 4 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.sclk === 1'b1 && prev === 1'b0) r++;
            prev = bus.sclk;
        end
        total++;
        if (r != 4) begin
            bad++;
            $display("FAIL rstmid_reach got=%0d exp=%0d", r, 4);
        end
        d0  = mon_done;
        rst = 1'b1;
        #1;
        obs = {bus.ss_n, bus.sclk, bus.mosi, bus.busy, bus.done, bus.rx_data};
        total++;
        if (obs !== 13'b1_0_0_0_0_00000000) begin
            bad++;
            $display("FAIL rstmid_outputs got=%b exp=%b", obs, 13'b1_0_0_0_0_00000000);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4 * 18 * DIV) @(posedge clk);
        @(negedge clk); #1;
        total++;
        if (mon_done != d0 || bus.busy !== 1'b0 || bus.ss_n !== 1'b1 || bus.rx_data !== 8'h00) begin
            bad++;
            $display("FAIL rstmid_aborted got=%0d dones busy %b rx %h exp=0 dones busy 0 rx 00",
                     mon_done - d0, bus.busy, bus.rx_data);
        end
        slv_byte = 8'h96;
        n0 = mon_mosi_q.size();
        drive_start(8'h81);
        wait_done(cyc, to);
        settle();
        total++;
        if (to || bus.rx_data !== 8'h96 || mosi_byte(n0) !== 8'h81) begin
            bad++;
            $display("FAIL rstmid_next got=%h/%h exp=%h/%h", bus.rx_data, mosi_byte(n0), 8'h96, 8'h81);
        end
    endtask

    task automatic test_hold_start();
        int n0, d0, r0, cyc, err;
        bit to;
        slv_byte = 8'h69;
        n0 = mon_mosi_q.size();
        d0 = mon_done;
        r0 = mon_rises;
        drive_start(8'h01);
        repeat (18 * DIV - 1) @(posedge clk);
        #1;
        bus.tx_data = 8'h80;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++;
        if (bus.done !== 1'b1 || bus.rx_data !== 8'h69) begin
            bad++;
            $display("FAIL hold_first_done got=%b/%h exp=1/%h", bus.done, bus.rx_data, 8'h69);
        end
        if (BURST) begin
            wait_done(cyc, to);
            settle();
            total++;
            if (to || cyc != 17 * DIV - 1 || mon_last_run != 35 * DIV) begin
                bad++;
                $display("FAIL burst_timing got=%0d/%0d exp=%0d/%0d", cyc, mon_last_run, 17 * DIV - 1, 35 * DIV);
            end
            total++;
            if (mon_done - d0 != 2 || mon_rises - r0 != 16 ||
                mosi_byte(n0) !== 8'h01 || mosi_byte(n0 + 8) !== 8'h80 || bus.rx_data !== 8'h69) begin
                bad++;
                $display("FAIL burst_frames got=%0d dones %0d rises exp=2 dones 16 rises",
                         mon_done - d0, mon_rises - r0);
            end
        end else begin
            err = 0;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (bus.busy !== 1'b0 || bus.ss_n !== 1'b1) err++;
            end
            settle();
            total++;
            if (err != 0 || mon_done - d0 != 1 || mon_rises - r0 != 8 || mosi_byte(n0) !== 8'h01) begin
                bad++;
                $display("FAIL hold_start_ignored got=%0d busy cycles %0d dones exp=0 busy cycles 1 done",
                         err, mon_done - d0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_div1();
        test_start_held();
        test_reset_mid();
        test_hold_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: transfer request, sampled only when idle.
REQ-005 The block SHALL have port tx_data, input, 8 bits: byte to send, latched on an accepted start.
REQ-006 The block SHALL have port busy, output, 1 bit: high while a transfer is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse at transfer completion.
REQ-008 The block SHALL have port rx_data, output, 8 bits: last received byte.
REQ-009 The block SHALL have port sclk, output, 1 bit: SPI clock, mode 0 (idle low).
REQ-010 The block SHALL have port mosi, output, 1 bit: serial data out, MSB first.
REQ-011 The block SHALL have port miso, input, 1 bit: serial data in, MSB first.
REQ-012 The block SHALL have port ss_n, output, 1 bit: active-low slave select.

Function
REQ-013 The block SHALL implement states IDLE, SETUP, XFER and HOLD, driven by a half-period counter that counts CLK_DIV clk cycles per phase.
REQ-014 In IDLE, start=1 SHALL latch tx_data, drive ss_n=0, busy=1 and mosi=tx_data[7] on the same edge, and enter SETUP.
REQ-015 SETUP SHALL last CLK_DIV cycles with sclk=0, then enter XFER.
REQ-016 XFER SHALL produce 16 sclk half-periods of CLK_DIV cycles each, starting with the rising edge.
REQ-017 On each sclk rising edge, miso SHALL be sampled into the rx shift register, MSB first.
REQ-018 On each of the first 7 sclk falling edges, mosi SHALL advance to the next lower tx bit.
REQ-019 After the 8th falling edge (sclk=0), the block SHALL enter HOLD for CLK_DIV cycles.
REQ-020 At HOLD exit, the block SHALL drive ss_n=1, busy=0 and done=1 for exactly one cycle, update rx_data, drive mosi=0, and enter IDLE.
REQ-021 ss_n SHALL stay low for exactly 18*CLK_DIV cycles per single transfer.
REQ-022 start while busy=1 SHALL be ignored; a start in the done cycle SHALL be accepted, and the next transfer begins with ss_n low one cycle later.
REQ-023 rx_data SHALL hold its value between transfers; tx_data changes after acceptance SHALL have no effect.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, ss_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=8'h00, and clear all counters and shift registers.
REQ-025 Reset asserted mid-transfer SHALL abort it with no done pulse; after release, the block SHALL be idle.

Configuration
REQ-026 Macro SPI_MASTER_BURST_EN defined: start=1 in the last HOLD cycle SHALL pulse done, update rx_data, keep ss_n=0 and busy=1, latch the new tx_data, set mosi to its bit 7, and enter XFER directly (no SETUP).
REQ-027 Macro SPI_MASTER_BURST_EN undefined: start during HOLD SHALL be ignored, and every transfer SHALL follow REQ-014..REQ-021.

Verification
REQ-028 CLK_DIV=2, tx_data=8'hA5, miso loopback from a mode-0 slave returning 8'h3C -> mosi carries 1,0,1,0,0,1,0,1; rx_data=8'h3C; ss_n low 36 cycles; one done pulse.
REQ-029 CLK_DIV=1, tx_data=8'hFF, miso=0 -> sclk toggles every cycle, 8 rising edges, rx_data=8'h00, done 18 cycles after start accepted.
REQ-030 start held high for the whole transfer of 8'h12 -> exactly one transfer; start still high in the done cycle starts a second transfer, with ss_n high for exactly one cycle between.
REQ-031 rst pulsed at the 4th sclk rising edge of 8'h81 -> ss_n=1, sclk=0, busy=0, no done, rx_data=8'h00; next transfer completes normally.
REQ-032 SPI_MASTER_BURST_EN defined, bytes 8'h01 then 8'h80 with start in the last HOLD cycle -> ss_n low continuously for 35*CLK_DIV cycles, two done pulses, 16 sclk rising edges.
